program_counter_unit: RTL and testbench
=======================================

Name: program_counter_unit

Overview:
Parametrised next-generation fetch-address unit for the single-cycle MIPS core. Holds the PC register and selects the next PC from sequential, branch, jump, jump-register, return-address-stack and exception sources. Adds stall, exception vectoring with EPC capture, and a configurable-depth return-address stack (RAS). Sits between control/branch logic and instruction memory.

Parameters:
ADDR_WIDTH, 32, width of PC, EPC and all address datapaths (>=28)
RESET_VECTOR, 32'h0040_0000, PC value loaded on reset (low 2 bits must be 0)
EXC_VECTOR, 32'h8000_0180, PC loaded on exception (low 2 bits must be 0)
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
stall  input  1  hold PC, EPC and RAS this cycle
branch_taken  input  1  take conditional branch
branch_offset  input  16  signed word offset
jump  input  1  take J-type jump
jump_target  input  26  J-type word target field
jump_reg  input  1  take register jump
reg_target  input  ADDR_WIDTH  register jump address
call  input  1  push pc_plus4 onto RAS (qualifies jump/jump_reg)
ret  input  1  next PC from RAS top
exception  input  1  vector to EXC_VECTOR
pc  output  ADDR_WIDTH  current fetch address
pc_plus4  output  ADDR_WIDTH  pc + 4, combinational
epc  output  ADDR_WIDTH  exception PC
ras_empty  output  1  RAS holds 0 entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_fault  output  1  one-cycle pulse on overflow/underflow
misaligned  output  1  one-cycle pulse on misaligned reg_target

Behaviour:
- Reset (reset=0, async): pc=RESET_VECTOR, epc=0, RAS count=0, ras_empty=1, ras_full=0, ras_fault=0, misaligned=0. Release synchronised to clock edge only by flop behaviour; first update on first rising edge with reset=1.
- All arithmetic mod 2^ADDR_WIDTH; wrap-around silent. pc_plus4 = pc+4.
- Next-PC priority per rising edge (highest first):
  1. exception: epc<=pc, pc<=EXC_VECTOR; ignores stall; RAS unchanged; all other requests dropped.
  2. stall: pc, epc, RAS, count hold; ras_fault/misaligned driven 0.
  3. ret: pc<=RAS top, pop. If empty: pc<=pc_plus4, count stays 0, ras_fault pulses.
  4. jump_reg: if reg_target[1:0]!=0 -> misaligned pulses, epc<=pc, pc<=EXC_VECTOR; else pc<=reg_target.
  5. jump: pc<={pc_plus4[W-1:28], jump_target, 2'b00}.
  6. branch_taken: pc<=pc_plus4 + (sign-extended branch_offset << 2).
  7. else pc<=pc_plus4.
- pc[1:0] always 0 after any update.
- RAS: circular buffer, pointer+count. call with a taken jump/jump_reg (and no exception/stall/misalign) pushes pc_plus4. Push when full overwrites oldest entry, count stays RAS_DEPTH, ras_fault pulses. call without jump/jump_reg ignored.
- ret and call together: pop supplies target, then pc_plus4 written to same top slot; count unchanged; no fault even if full. Underflow rules still apply when empty (push occurs, count=1, fault pulses).
- ras_fault, misaligned are registered pulses, high exactly the cycle after the event.
- Reset asserted mid-operation: all state to reset values immediately, regardless of clock.

Test Plan:
- Reset then 3 free-running cycles -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; epc=0, ras_empty=1.
- pc=0x00400010, branch_taken, offset=16'hFFFC -> pc=0x00400004; offset=16'h0003 -> 0x00400020; jump, target=26'h0100000 -> 0x00400000.
- jump+call from 0x00400100 x5 (DEPTH=4) -> ras_full after 4, ras_fault pulse on 5th; 4 rets return 0x00400114,0x00400110,0x0040010C,0x00400108; 5th ret -> pc_plus4, ras_fault.
- stall high 3 cycles at pc=0x00400040 with branch_taken -> pc holds 0x00400040; exception during stall -> pc=0x80000180, epc=0x00400040.
- jump_reg reg_target=0x00400006 -> misaligned pulse, pc=0x80000180, epc=faulting pc; reg_target=0x00400008 -> pc=0x00400008.
- reset driven low between clock edges mid-sequence -> pc=0x00400000 immediately, RAS empty.

Source files
------------

// File: rtl/program_counter_unit.sv
// Fetch-address unit: PC register with prioritised next-PC selection, exception
// vectoring with EPC capture, and a circular return-address stack.
module program_counter_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(32'h0040_0000),
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(32'h8000_0180),
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_offset,
  input  logic                  jump,
  input  logic [25:0]           jump_target,
  input  logic                  jump_reg,
  input  logic [ADDR_WIDTH-1:0] reg_target,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  exception,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_fault,
  output logic                  misaligned
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]        CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]        CNT_FULL  = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] HIGH_MASK = ~ADDR_WIDTH'(28'hFFF_FFFF);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_epc;
  logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W:0]        r_count;
  logic                  r_rasFault;
  logic                  r_misaligned;

  logic [ADDR_WIDTH-1:0] w_pcPlus4;
  logic [ADDR_WIDTH-1:0] w_branchTarget;
  logic [ADDR_WIDTH-1:0] w_jumpTarget;
  logic [ADDR_WIDTH-1:0] w_rasTop;
  logic [PTR_W-1:0]      w_topIdx;
  logic                  w_rasEmpty;
  logic                  w_rasFull;
  logic                  w_regMisaligned;
  logic [ADDR_WIDTH-1:0] w_nextPc;
  logic [ADDR_WIDTH-1:0] w_nextEpc;
  logic                  w_rasPush;
  logic                  w_rasPop;
  logic                  w_rasReplace;
  logic                  w_faultNext;
  logic                  w_misNext;

  assign w_pcPlus4       = r_pc + PC_STEP;
  assign w_branchTarget  = w_pcPlus4 +
                           {{(ADDR_WIDTH - 18){branch_offset[15]}}, branch_offset, 2'b00};
  assign w_jumpTarget    = (w_pcPlus4 & HIGH_MASK) | ADDR_WIDTH'({jump_target, 2'b00});
  assign w_topIdx        = r_wrPtr - PTR_ONE;
  assign w_rasTop        = r_ras[w_topIdx];
  assign w_rasEmpty      = (r_count == '0);
  assign w_rasFull       = (r_count == CNT_FULL);
  assign w_regMisaligned = |reg_target[1:0];

  always_comb begin
    w_nextPc     = w_pcPlus4;
    w_nextEpc    = r_epc;
    w_rasPush    = 1'b0;
    w_rasPop     = 1'b0;
    w_rasReplace = 1'b0;
    w_faultNext  = 1'b0;
    w_misNext    = 1'b0;
    if (exception) begin
      w_nextPc  = EXC_VECTOR;
      w_nextEpc = r_pc;
    end else if (stall) begin
      w_nextPc = r_pc;
    end else if (ret) begin
      // Empty-stack return falls through sequentially; a paired call still pushes.
      if (w_rasEmpty) begin
        w_faultNext = 1'b1;
        w_rasPush   = call;
      end else begin
        w_nextPc     = w_rasTop;
        w_rasPop     = ~call;
        w_rasReplace = call;
      end
    end else if (jump_reg) begin
      if (w_regMisaligned) begin
        w_misNext = 1'b1;
        w_nextPc  = EXC_VECTOR;
        w_nextEpc = r_pc;
      end else begin
        w_nextPc    = reg_target;
        w_rasPush   = call;
        w_faultNext = call & w_rasFull;
      end
    end else if (jump) begin
      w_nextPc    = w_jumpTarget;
      w_rasPush   = call;
      w_faultNext = call & w_rasFull;
    end else if (branch_taken) begin
      w_nextPc = w_branchTarget;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_wrPtr      <= '0;
      r_count      <= '0;
      r_rasFault   <= 1'b0;
      r_misaligned <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else begin
      r_pc         <= w_nextPc;
      r_epc        <= w_nextEpc;
      r_rasFault   <= w_faultNext;
      r_misaligned <= w_misNext;
      // A full-stack push lands on the oldest slot, which is where the write pointer sits.
      if (w_rasPush) begin
        r_ras[r_wrPtr] <= w_pcPlus4;
        r_wrPtr        <= r_wrPtr + PTR_ONE;
        if (!w_rasFull) r_count <= r_count + CNT_ONE;
      end else if (w_rasPop) begin
        r_wrPtr <= w_topIdx;
        r_count <= r_count - CNT_ONE;
      end else if (w_rasReplace) begin
        r_ras[w_topIdx] <= w_pcPlus4;
      end
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pcPlus4;
  assign epc        = r_epc;
  assign ras_empty  = w_rasEmpty;
  assign ras_full   = w_rasFull;
  assign ras_fault  = r_rasFault;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboarded random and directed bench for program_counter_unit against a
// queue-based behavioural model of the fetch-address rules.
module tb_program_counter_unit;

  localparam logic [31:0] RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0180;
  localparam int          DEPTH     = 4;

  typedef struct packed {
    logic        stall;
    logic        branchTaken;
    logic [15:0] branchOffset;
    logic        jump;
    logic [25:0] jumpTarget;
    logic        jumpReg;
    logic [31:0] regTarget;
    logic        call;
    logic        ret;
    logic        exception;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] epc;
    logic        empty;
    logic        full;
    logic        fault;
    logic        mis;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = '0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        exception = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_fault;
  logic        misaligned;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  exp_t        expQ[$];
  logic [31:0] mPc;
  logic [31:0] mEpc;
  logic [31:0] mRas[$];

  program_counter_unit #(
    .ADDR_WIDTH(32), .RESET_VECTOR(RESET_VEC), .EXC_VECTOR(EXC_VEC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .jump_reg(jump_reg), .reg_target(reg_target), .call(call), .ret(ret),
    .exception(exception), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_fault(ras_fault),
    .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic exp_t modelView(logic fault, logic mis);
    exp_t e;
    e.pc      = mPc;
    e.pcPlus4 = mPc + 32'd4;
    e.epc     = mEpc;
    e.empty   = (mRas.size() == 0);
    e.full    = (mRas.size() == DEPTH);
    e.fault   = fault;
    e.mis     = mis;
    return e;
  endfunction

  task automatic modelReset();
    mPc  = RESET_VEC;
    mEpc = 32'd0;
    mRas.delete();
  endtask

  // A push onto a full stack discards the oldest return address and flags a fault.
  task automatic modelPush(input logic [31:0] addr, inout logic fault);
    if (mRas.size() == DEPTH) begin
      mRas.delete(0);
      fault = 1'b1;
    end
    mRas.push_back(addr);
  endtask

  task automatic modelStep(input stim_t s, output exp_t e);
    logic [31:0] seq;
    logic        fault;
    logic        mis;
    int          delta;
    seq   = mPc + 32'd4;
    fault = 1'b0;
    mis   = 1'b0;
    if (s.exception) begin
      mEpc = mPc;
      mPc  = EXC_VEC;
    end else if (s.stall) begin
      mPc = mPc;
    end else if (s.ret) begin
      if (mRas.size() == 0) begin
        mPc   = seq;
        fault = 1'b1;
        if (s.call) mRas.push_back(seq);
      end else begin
        mPc = mRas.pop_back();
        if (s.call) mRas.push_back(seq);
      end
    end else if (s.jumpReg) begin
      if (s.regTarget % 4 != 0) begin
        mis  = 1'b1;
        mEpc = mPc;
        mPc  = EXC_VEC;
      end else begin
        mPc = s.regTarget;
        if (s.call) modelPush(seq, fault);
      end
    end else if (s.jump) begin
      mPc = (seq & 32'hF000_0000) + ({6'd0, s.jumpTarget} * 32'd4);
      if (s.call) modelPush(seq, fault);
    end else if (s.branchTaken) begin
      delta = int'($signed(s.branchOffset)) * 4;
      mPc   = seq + 32'(delta);
    end else begin
      mPc = seq;
    end
    e = modelView(fault, mis);
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("[TB] FAIL %s pc got %h want %h", name, pc, e.pc);
    end
    checks++;
    if (pc_plus4 !== e.pcPlus4) begin
      errors++;
      $display("[TB] FAIL %s pc_plus4 got %h want %h", name, pc_plus4, e.pcPlus4);
    end
    checks++;
    if (epc !== e.epc) begin
      errors++;
      $display("[TB] FAIL %s epc got %h want %h", name, epc, e.epc);
    end
    checks++;
    if ({ras_empty, ras_full} !== {e.empty, e.full}) begin
      errors++;
      $display("[TB] FAIL %s empty/full got %b%b want %b%b", name, ras_empty, ras_full,
               e.empty, e.full);
    end
    checks++;
    if ({ras_fault, misaligned} !== {e.fault, e.mis}) begin
      errors++;
      $display("[TB] FAIL %s fault/misaligned got %b%b want %b%b", name, ras_fault,
               misaligned, e.fault, e.mis);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clock);
    reset         = 1'b1;
    stall         = s.stall;
    branch_taken  = s.branchTaken;
    branch_offset = s.branchOffset;
    jump          = s.jump;
    jump_target   = s.jumpTarget;
    jump_reg      = s.jumpReg;
    reg_target    = s.regTarget;
    call          = s.call;
    ret           = s.ret;
    exception     = s.exception;
    modelStep(s, e);
    expQ.push_back(e);
  endtask

  task automatic goTo(input logic [31:0] addr);
    stim_t s;
    s           = idle();
    s.jumpReg   = 1'b1;
    s.regTarget = addr;
    applyStimulus(s);
  endtask

  // Every rising edge out of reset presents a new PC; the monitor retires one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset && expQ.size() > 0) begin
        e = expQ.pop_front();
        cycleNo++;
        checkOutput($sformatf("cycle%0d", cycleNo), e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t s;
    modelReset();
    #12;
    checkOutput("reset", modelView(1'b0, 1'b0));

    repeat (3) applyStimulus(idle());

    goTo(32'h0040_0010);
    s = idle(); s.branchTaken = 1'b1; s.branchOffset = 16'hFFFC;
    applyStimulus(s);
    goTo(32'h0040_0010);
    s = idle(); s.branchTaken = 1'b1; s.branchOffset = 16'h0003;
    applyStimulus(s);
    s = idle(); s.jump = 1'b1; s.jumpTarget = 26'h010_0000;
    applyStimulus(s);

    goTo(32'h0040_0100);
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.jump = 1'b1; s.call = 1'b1;
      s.jumpTarget = 26'((mPc + 32'd4) >> 2);
      applyStimulus(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.ret = 1'b1;
      applyStimulus(s);
    end

    goTo(32'h0040_0040);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1'b1; s.branchTaken = 1'b1; s.branchOffset = 16'h0010;
      applyStimulus(s);
    end
    s = idle(); s.stall = 1'b1; s.exception = 1'b1; s.ret = 1'b1;
    applyStimulus(s);

    goTo(32'h0040_0020);
    s = idle(); s.jumpReg = 1'b1; s.regTarget = 32'h0040_0006; s.call = 1'b1;
    applyStimulus(s);
    s = idle(); s.jumpReg = 1'b1; s.regTarget = 32'h0040_0008;
    applyStimulus(s);

    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.stall        = ($urandom_range(0, 9) == 0);
      s.exception    = ($urandom_range(0, 29) == 0);
      s.branchTaken  = ($urandom_range(0, 9) < 3);
      s.branchOffset = 16'($urandom);
      s.jump         = ($urandom_range(0, 9) < 2);
      s.jumpTarget   = 26'h010_0000 + 26'($urandom_range(0, 511));
      s.jumpReg      = ($urandom_range(0, 19) < 3);
      s.regTarget    = 32'h0040_0000 + 32'($urandom_range(0, 1023)) * 32'd4;
      if ($urandom_range(0, 5) == 0) s.regTarget = s.regTarget + 32'($urandom_range(1, 3));
      s.ret          = ($urandom_range(0, 19) < 3);
      s.call         = (s.jump || s.jumpReg) && ($urandom_range(0, 1) == 1);
      applyStimulus(s);
      if (i == 300) begin
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset", modelView(1'b0, 1'b0));
      end
    end

    @(posedge clock);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending got %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
